best_time_ranker: RTL and testbench

Downstream consumer of the stopwatch time word. It captures the time of each completed run and keeps a ranked table of the three best times per stopwatch mode (count-up and count-down). It reports where the latest run placed, using a rank LED, a mode LED and a new-record pulse. A registered read port supplies table entries to the display path.

---
 rtl/best_time_ranker.sv | 189 ++++++++++++++++++
 tb/tb_best_time_ranker.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/best_time_ranker.sv
// best_time_ranker
//   Keeps the three best (smallest) stopwatch times per mode: an up table
//   and a down table. Each completed run is scanned against its table,
//   inserted if it places, and the placement is reported on rank_led,
//   lb_mode and new_record.
//
// Ports
//   clock, reset    : clock, asynchronous active-high reset
//   time_in         : stopwatch time word, compared as unsigned
//   run_done        : one-cycle pulse when a run stops
//   mode            : table of the finished run (0 = up, 1 = down)
//   clear           : synchronous wipe of both tables, aborts any insertion
//   rd_sel          : [2] table, [1:0] index (0 = best, 3 = reads as empty)
//   rd_time/rd_valid: registered read of the selected entry
//   busy            : high in SCAN, INSERT and REPORT
//   rank_led        : one-hot placement of the last accepted run (bit0 = 1st)
//   lb_mode         : one-hot table of the last accepted run ({down, up})
//   new_record      : one-cycle pulse when the last run took 1st place
//
// Optional build macro: RANKER_SOUND_EN adds sound_pulse[2:0], a one-cycle
// copy of the rank code during REPORT for the music block.
module best_time_ranker #(
  parameter int TW    = 39,
  parameter int DEPTH = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [TW-1:0] time_in,
  input  logic          run_done,
  input  logic          mode,
  input  logic          clear,
  input  logic [2:0]    rd_sel,
  output logic [TW-1:0] rd_time,
  output logic          rd_valid,
  output logic          busy,
  output logic [2:0]    rank_led,
  output logic [1:0]    lb_mode,
  output logic          new_record
`ifdef RANKER_SOUND_EN
  ,
  output logic [2:0]    sound_pulse
`endif
);

  localparam logic [1:0] LAST = 2'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, INSERT, REPORT} state_t;

  state_t                      state_q, state_d;
  logic [TW-1:0]               cand_q, cand_d;
  logic                        cmode_q, cmode_d;
  logic [1:0]                  idx_q, idx_d;
  logic [1:0]                  pos_q, pos_d;
  logic                        placed_q, placed_d;
  logic [1:0][2:0][TW-1:0]     ent_q, ent_d;
  logic [1:0][2:0]             vld_q, vld_d;
  logic [2:0]                  rank_led_q, rank_led_d;
  logic [1:0]                  lb_mode_q, lb_mode_d;
  logic [TW-1:0]               rd_time_q, rd_time_d;
  logic                        rd_valid_q, rd_valid_d;

  // Candidate beats the slot if the slot is empty or strictly larger;
  // a tie leaves the existing entry ahead.
  logic hit;
  assign hit = !vld_q[cmode_q][idx_q] || (cand_q < ent_q[cmode_q][idx_q]);

  // ---------------- state register ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      cmode_q    <= 1'b0;
      idx_q      <= '0;
      pos_q      <= '0;
      placed_q   <= 1'b0;
      ent_q      <= '0;
      vld_q      <= '0;
      rank_led_q <= '0;
      lb_mode_q  <= '0;
      rd_time_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cmode_q    <= cmode_d;
      idx_q      <= idx_d;
      pos_q      <= pos_d;
      placed_q   <= placed_d;
      ent_q      <= ent_d;
      vld_q      <= vld_d;
      rank_led_q <= rank_led_d;
      lb_mode_q  <= lb_mode_d;
      rd_time_q  <= rd_time_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run_done && time_in != '0) state_d = SCAN;
      SCAN:    if (hit) state_d = INSERT;
               else if (idx_q == LAST) state_d = REPORT;
      INSERT:  state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // ---------------- datapath / outputs ----------------
  always_comb begin
    cand_d     = cand_q;
    cmode_d    = cmode_q;
    idx_d      = idx_q;
    pos_d      = pos_q;
    placed_d   = placed_q;
    ent_d      = ent_q;
    vld_d      = vld_q;
    rank_led_d = rank_led_q;
    lb_mode_d  = lb_mode_q;
    case (state_q)
      IDLE: begin
        // run_done while busy never reaches here, so it is dropped for free
        if (run_done && time_in != '0) begin
          cand_d   = time_in;
          cmode_d  = mode;
          idx_d    = '0;
          placed_d = 1'b0;
        end
      end
      SCAN: begin
        if (hit)                pos_d = idx_q;
        else if (idx_q != LAST) idx_d = idx_q + 2'd1;
      end
      INSERT: begin
        // Shift entries at and below pos down one slot; slot 2 falls off.
        if (pos_q < 2'd2) begin
          ent_d[cmode_q][2] = ent_q[cmode_q][1];
          vld_d[cmode_q][2] = vld_q[cmode_q][1];
        end
        if (pos_q == 2'd0) begin
          ent_d[cmode_q][1] = ent_q[cmode_q][0];
          vld_d[cmode_q][1] = vld_q[cmode_q][0];
        end
        ent_d[cmode_q][pos_q] = cand_q;
        vld_d[cmode_q][pos_q] = 1'b1;
        placed_d              = 1'b1;
      end
      REPORT: begin
        rank_led_d = placed_q ? (3'b001 << pos_q) : 3'b000;
        lb_mode_d  = cmode_q ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
    if (clear) begin
      ent_d      = '0;
      vld_d      = '0;
      rank_led_d = '0;
      lb_mode_d  = '0;
    end
  end

  // Read port samples the current flops, so an INSERT edge returns old data.
  always_comb begin
    rd_time_d  = '0;
    rd_valid_d = 1'b0;
    if (rd_sel[1:0] != 2'd3) begin
      rd_time_d  = ent_q[rd_sel[2]][rd_sel[1:0]];
      rd_valid_d = vld_q[rd_sel[2]][rd_sel[1:0]];
    end
  end

  logic report_now;
  assign report_now = (state_q == REPORT) && placed_q && !clear;

  assign busy       = (state_q != IDLE);
  assign rank_led   = rank_led_q;
  assign lb_mode    = lb_mode_q;
  assign rd_time    = rd_time_q;
  assign rd_valid   = rd_valid_q;
  assign new_record = report_now && (pos_q == 2'd0);

`ifdef RANKER_SOUND_EN
  assign sound_pulse = report_now ? (3'b001 << pos_q) : 3'b000;
`endif

endmodule

// File: tb/tb_best_time_ranker.sv
module tb_best_time_ranker;
  localparam int TW = 39;

  logic          clock = 1'b0;
  logic          reset, run_done, mode, clear;
  logic [TW-1:0] time_in;
  logic [2:0]    rd_sel;
  logic [TW-1:0] rd_time;
  logic          rd_valid, busy, new_record;
  logic [2:0]    rank_led;
  logic [1:0]    lb_mode;
`ifdef RANKER_SOUND_EN
  logic [2:0]    sound_pulse;
`endif

  best_time_ranker #(.TW(TW), .DEPTH(3)) dut (
    .clock(clock), .reset(reset), .time_in(time_in), .run_done(run_done),
    .mode(mode), .clear(clear), .rd_sel(rd_sel), .rd_time(rd_time),
    .rd_valid(rd_valid), .busy(busy), .rank_led(rank_led),
    .lb_mode(lb_mode), .new_record(new_record)
`ifdef RANKER_SOUND_EN
    , .sound_pulse(sound_pulse)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] rank;
    logic [1:0] lb;
    int         nrec;
    int         bc;
  } exp_t;

  exp_t          sb[$];
  logic [TW-1:0] mt[2][3];
  bit            mv[2][3];
  int            checks = 0, errors = 0, nr_cnt = 0, snd_bad = 0;

  always @(negedge clock) if (new_record) nr_cnt++;
`ifdef RANKER_SOUND_EN
  always @(negedge clock) if (sound_pulse != 3'b000 && new_record == 1'b0 && rank_led == 3'b000 && !busy) snd_bad++;
`endif

  task automatic model_clear();
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 3; i++) begin mt[t][i] = '0; mv[t][i] = 0; end
  endtask

  // Reference ranking: smaller wins, ties go below, empty slots lose.
  task automatic model_run(input logic [TW-1:0] t, input logic m, output exp_t e);
    int p = 3;
    for (int i = 0; i < 3; i++)
      if (p == 3 && (!mv[m][i] || t < mt[m][i])) p = i;
    if (p < 3) begin
      for (int i = 2; i > p; i--) begin mt[m][i] = mt[m][i-1]; mv[m][i] = mv[m][i-1]; end
      mt[m][p] = t; mv[m][p] = 1;
    end
    e.rank = (p < 3) ? 3'(1 << p) : 3'b000;
    e.lb   = m ? 2'b10 : 2'b01;
    e.nrec = (p == 0) ? 1 : 0;
    e.bc   = (p < 3) ? p + 3 : 4;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 20) begin @(negedge clock); n++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", n);
    end
  endtask

  // One run; with poke set a second run_done (time 100) is driven while busy.
  task automatic run(input logic [TW-1:0] t, input logic m, input bit poke);
    exp_t e; int nr0, bc;
    model_run(t, m, e);
    sb.push_back(e);
    nr0 = nr_cnt;
    @(negedge clock); time_in = t; mode = m; run_done = 1;
    @(negedge clock);
    if (poke) begin time_in = 100; run_done = 1; @(negedge clock); bc = 1; end
    else bc = 0;
    run_done = 0;
    begin int n; wait_idle(n); bc += n; end
    e = sb.pop_front();
    checks++; if (rank_led !== e.rank) begin errors++; $display("FAIL rank_led t=%0d: got %b, required %b", t, rank_led, e.rank); end
    checks++; if (lb_mode !== e.lb) begin errors++; $display("FAIL lb_mode t=%0d: got %b, required %b", t, lb_mode, e.lb); end
    checks++; if (nr_cnt - nr0 != e.nrec) begin errors++; $display("FAIL new_record t=%0d: got %0d pulses, required %0d", t, nr_cnt - nr0, e.nrec); end
    checks++; if (bc != e.bc) begin errors++; $display("FAIL busy_cycles t=%0d: got %0d, required %0d", t, bc, e.bc); end
  endtask

  task automatic check_tables(input string tag);
    for (int tb = 0; tb < 2; tb++)
      for (int i = 0; i < 4; i++) begin
        logic [TW-1:0] et; logic ev;
        et = (i < 3) ? mt[tb][i] : '0;
        ev = (i < 3) ? mv[tb][i] : 1'b0;
        if (!ev) et = '0;
        @(negedge clock); rd_sel = {1'(tb), 2'(i)};
        @(negedge clock);
        checks++;
        if (rd_valid !== ev || rd_time !== et) begin
          errors++;
          $display("FAIL table_%s[%0d][%0d]: got v=%b t=%0d, required v=%b t=%0d", tag, tb, i, rd_valid, rd_time, ev, et);
        end
      end
  endtask

  task automatic test_reset();
    reset = 1; run_done = 0; mode = 0; clear = 0; time_in = '0; rd_sel = '0;
    model_clear();
    repeat (3) @(negedge clock);
    reset = 0;
    checks++; if (rank_led !== 3'b000 || lb_mode !== 2'b00) begin errors++; $display("FAIL reset_leds: got %b/%b, required 000/00", rank_led, lb_mode); end
    checks++; if (busy !== 1'b0 || new_record !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b/%b, required 0/0", busy, new_record); end
    check_tables("reset");
  endtask

  task automatic test_up_runs();
    run(500, 0, 0);
    run(300, 0, 0);
    run(700, 0, 0);
    check_tables("up3");
  endtask

  task automatic test_no_place();
    run(800, 0, 0);
    run(400, 0, 0);
    check_tables("up5");
  endtask

  task automatic test_tie();
    run(250, 1, 0);
    run(250, 1, 0);
    check_tables("tie");
  endtask

  task automatic test_ignored();
    int nr0 = nr_cnt;
    @(negedge clock); time_in = '0; mode = 0; run_done = 1;
    @(negedge clock); run_done = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_run_busy: got %b, required 0", busy); end
    @(negedge clock);
    checks++; if (rank_led !== 3'b010 || lb_mode !== 2'b10 || nr_cnt != nr0) begin
      errors++; $display("FAIL zero_run_leds: got %b/%b nr=%0d, required 010/10 nr=0", rank_led, lb_mode, nr_cnt - nr0);
    end
    run(600, 0, 1);
    check_tables("ign");
  endtask

  task automatic test_clear();
    int nr0;
    run(350, 0, 0);
    nr0 = nr_cnt;
    @(negedge clock); time_in = 100; mode = 1; run_done = 1;
    @(negedge clock); time_in = 50; run_done = 1; clear = 1;
    @(negedge clock); clear = 0; run_done = 0;
    model_clear();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b, required 0", busy); end
    checks++; if (rank_led !== 3'b000 || lb_mode !== 2'b00) begin errors++; $display("FAIL clear_leds: got %b/%b, required 000/00", rank_led, lb_mode); end
    repeat (3) @(negedge clock);
    checks++; if (nr_cnt != nr0 || busy !== 1'b0) begin errors++; $display("FAIL clear_after: got nr=%0d busy=%b, required 0/0", nr_cnt - nr0, busy); end
    check_tables("clr");
    run(900, 0, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clock); time_in = 100; mode = 0; run_done = 1;
    @(negedge clock); run_done = 0; reset = 1;
    #1;
    checks++; if (busy !== 1'b0 || rank_led !== 3'b000 || lb_mode !== 2'b00) begin
      errors++; $display("FAIL reset_mid: got busy=%b rank=%b lb=%b, required 0/000/00", busy, rank_led, lb_mode);
    end
    @(negedge clock); reset = 0;
    model_clear();
    check_tables("rstmid");
  endtask

  initial begin
    test_reset();
    test_up_runs();
    test_no_place();
    test_tie();
    test_ignored();
    test_clear();
    test_reset_mid();
    checks++; if (snd_bad != 0) begin errors++; $display("FAIL sound_idle: got %0d stray pulses, required 0", snd_bad); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
